respawn_sequencer: RTL and testbench

- Sequences the death/respawn cycle of the active level in the game logic.
- Owns the lives count and gates player inputs into the level.
- Freezes play with a blinking Mario after a loss, then holds the level in reset until the player continues or the game is over.
- Sits between the top-level game state machine and the currently selected level instance, driving that level's reset and input-enable.

---
 rtl/respawn_sequencer_pkg.sv | 25 ++
 rtl/respawn_sequencer_tick_divider.sv | 31 +++
 rtl/respawn_sequencer.sv | 149 ++++++++++++++
 tb/tb_respawn_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/respawn_sequencer_pkg.sv
// Shared types and default timing constants for the death/respawn sequencer.
package respawn_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_FREEZE,
    ST_RESPAWN,
    ST_GAME_OVER
  } respawn_state_t;

  typedef logic [3:0] lives_t;

  localparam int DEF_START_LIVES  = 3;
  localparam int DEF_TICK_DIV     = 500_000;
  localparam int DEF_FREEZE_TICKS = 50;
  localparam int DEF_BLINK_TICKS  = 5;
  localparam int DEF_AUTO_TICKS   = 150;

  // Losing a life never wraps below zero.
  function automatic lives_t lives_dec(input lives_t l);
    return (l == 4'd0) ? l : l - 4'd1;
  endfunction

endpackage

// File: rtl/respawn_sequencer_tick_divider.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks;
// clear restarts the count so a new state sees a full first tick period.
module tick_divider
  import respawn_sequencer_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic vga_clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/respawn_sequencer.sv
// Death/respawn sequencer for the active level: owns lives, level reset and input gating.
// Optional RESPAWN_AUTO_EN: leave RESPAWN automatically after AUTO_TICKS ticks.
module respawn_sequencer
  import respawn_sequencer_pkg::*;
#(
  parameter int START_LIVES  = DEF_START_LIVES,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int FREEZE_TICKS = DEF_FREEZE_TICKS,
  parameter int BLINK_TICKS  = DEF_BLINK_TICKS,
  parameter int AUTO_TICKS   = DEF_AUTO_TICKS
) (
  input  logic   vga_clock,
  input  logic   reset,
  input  logic   start_button,
  input  logic   level_win,
  input  logic   level_lose,
  output logic   level_reset_n,
  output logic   input_enable,
  output logic   freeze,
  output logic   mario_visible,
  output logic   level_advance,
  output lives_t lives,
  output logic   game_over
);

  localparam int TMAX = (FREEZE_TICKS > AUTO_TICKS) ? FREEZE_TICKS : AUTO_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(BLINK_TICKS + 1);

  // Registered FSM state; visible for checkers binding into this instance.
  respawn_state_t state;
  logic [TW-1:0]  tick_cnt;
  logic [BW-1:0]  blink_cnt;
  logic           armed;
  logic           tick;

  logic start_go, lose_go, freeze_done, auto_done, respawn_go, clear;

  // Every state change is decoded here so the divider restarts on the same edge.
  assign start_go    = (state == ST_IDLE) && !start_button;
  assign lose_go     = (state == ST_PLAY) && !level_win && level_lose;
  assign freeze_done = (state == ST_FREEZE) && tick && (tick_cnt == TW'(FREEZE_TICKS - 1));
`ifdef RESPAWN_AUTO_EN
  assign auto_done   = (state == ST_RESPAWN) && tick && (tick_cnt == TW'(AUTO_TICKS - 1));
`else
  assign auto_done   = 1'b0;
`endif
  assign respawn_go  = (state == ST_RESPAWN) && ((armed && !start_button) || auto_done);
  assign clear       = start_go || lose_go || freeze_done || respawn_go;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
    .vga_clock (vga_clock),
    .reset     (reset),
    .clear     (clear),
    .tick      (tick)
  );

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      lives         <= lives_t'(START_LIVES);
      level_reset_n <= 1'b0;
      input_enable  <= 1'b0;
      freeze        <= 1'b0;
      mario_visible <= 1'b1;
      level_advance <= 1'b0;
      game_over     <= 1'b0;
      tick_cnt      <= '0;
      blink_cnt     <= '0;
      armed         <= 1'b0;
    end else begin
      level_advance <= 1'b0;
      if (clear) begin
        tick_cnt <= '0;
      end else if (tick && tick_cnt != TW'(TMAX)) begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start_go) begin
            state         <= ST_PLAY;
            level_reset_n <= 1'b1;
            input_enable  <= 1'b1;
          end
        end

        ST_PLAY: begin
          if (level_win) begin
            // Pulse the level's reset for the cycle the advance is signalled.
            level_advance <= 1'b1;
            level_reset_n <= 1'b0;
          end else if (level_lose) begin
            state         <= ST_FREEZE;
            lives         <= lives_dec(lives);
            level_reset_n <= 1'b1;
            input_enable  <= 1'b0;
            freeze        <= 1'b1;
            mario_visible <= 1'b1;
            blink_cnt     <= '0;
          end else begin
            level_reset_n <= 1'b1;
          end
        end

        ST_FREEZE: begin
          if (freeze_done) begin
            freeze        <= 1'b0;
            mario_visible <= 1'b1;
            level_reset_n <= 1'b0;
            if (lives == 4'd0) begin
              state     <= ST_GAME_OVER;
              game_over <= 1'b1;
            end else begin
              state <= ST_RESPAWN;
              armed <= 1'b0;
            end
          end else if (tick) begin
            if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
              blink_cnt     <= '0;
              mario_visible <= ~mario_visible;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end

        ST_RESPAWN: begin
          if (respawn_go) begin
            state         <= ST_PLAY;
            level_reset_n <= 1'b1;
            input_enable  <= 1'b1;
          end else if (start_button) begin
            armed <= 1'b1;
          end
        end

        ST_GAME_OVER: begin
          game_over     <= 1'b1;
          level_reset_n <= 1'b0;
          input_enable  <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_respawn_sequencer.sv
// Directed bench for respawn_sequencer: vector table for PLAY events, hand sequences for
// freeze timing, respawn arming, game over, asynchronous reset and automatic respawn.
module tb_respawn_sequencer;
  import respawn_sequencer_pkg::*;

  logic   clk = 1'b0;
  logic   reset;
  logic   start_button, level_win, level_lose;
  logic   level_reset_n, input_enable, freeze, mario_visible, level_advance, game_over;
  lives_t lives;

  int n_checks = 0;
  int n_fail   = 0;

  respawn_sequencer #(
    .START_LIVES (3),
    .TICK_DIV    (4),
    .FREEZE_TICKS(3),
    .BLINK_TICKS (1),
    .AUTO_TICKS  (2)
  ) dut (
    .vga_clock     (clk),
    .reset         (reset),
    .start_button  (start_button),
    .level_win     (level_win),
    .level_lose    (level_lose),
    .level_reset_n (level_reset_n),
    .input_enable  (input_enable),
    .freeze        (freeze),
    .mario_visible (mario_visible),
    .level_advance (level_advance),
    .lives         (lives),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  // Output bundle order: {level_reset_n, input_enable, freeze, mario_visible, level_advance, game_over, lives}
  function automatic logic [9:0] pk(input logic rn, input logic ie, input logic fr,
                                    input logic vis, input logic adv, input logic go,
                                    input lives_t l);
    return {rn, ie, fr, vis, adv, go, l};
  endfunction

  function automatic logic [9:0] obs();
    return {level_reset_n, input_enable, freeze, mario_visible, level_advance, game_over, lives};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (rn ie fr vis adv go lives)", name, act, exp);
    end
  endtask

  // One death from PLAY with start released; returns to PLAY unless it ends the game.
  task automatic lose_cycle(input lives_t l, input logic to_over);
    level_lose = 1'b1;
    step();
    level_lose = 1'b0;
    check("lose_entry", obs(), pk(1, 0, 1, 1, 0, 0, l));
    repeat (11) step();
    step();
    if (to_over) begin
      check("game_over_entry", obs(), pk(0, 0, 0, 1, 0, 1, l));
    end else begin
      check("lose_respawn", obs(), pk(0, 0, 0, 1, 0, 0, l));
      step();
      start_button = 1'b0;
      step();
      check("lose_replay", obs(), pk(1, 1, 0, 1, 0, 0, l));
      start_button = 1'b1;
    end
  endtask

  typedef struct {
    logic       start;
    logic       win;
    logic       lose;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{start:1'b1, win:1'b0, lose:1'b0, exp:pk(0, 0, 0, 1, 0, 0, 4'd3)};
    vecs[1] = '{start:1'b0, win:1'b0, lose:1'b0, exp:pk(1, 1, 0, 1, 0, 0, 4'd3)};
    vecs[2] = '{start:1'b1, win:1'b0, lose:1'b0, exp:pk(1, 1, 0, 1, 0, 0, 4'd3)};
    vecs[3] = '{start:1'b1, win:1'b1, lose:1'b0, exp:pk(0, 1, 0, 1, 1, 0, 4'd3)};
    vecs[4] = '{start:1'b1, win:1'b0, lose:1'b0, exp:pk(1, 1, 0, 1, 0, 0, 4'd3)};
    vecs[5] = '{start:1'b1, win:1'b1, lose:1'b1, exp:pk(0, 1, 0, 1, 1, 0, 4'd3)};
    vecs[6] = '{start:1'b1, win:1'b1, lose:1'b0, exp:pk(0, 1, 0, 1, 1, 0, 4'd3)};
    vecs[7] = '{start:1'b1, win:1'b0, lose:1'b0, exp:pk(1, 1, 0, 1, 0, 0, 4'd3)};
    vecs[8] = '{start:1'b1, win:1'b0, lose:1'b1, exp:pk(1, 0, 1, 1, 0, 0, 4'd2)};

    reset        = 1'b0;
    start_button = 1'b1;
    level_win    = 1'b0;
    level_lose   = 1'b0;
    step();
    step();
    check("reset_values", obs(), pk(0, 0, 0, 1, 0, 0, 4'd3));
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      start_button = vecs[i].start;
      level_win    = vecs[i].win;
      level_lose   = vecs[i].lose;
      step();
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end

    // FREEZE: 12 cycles, blink period 4, start held low, stray win/lose ignored.
    level_win    = 1'b0;
    level_lose   = 1'b0;
    start_button = 1'b0;
    for (int k = 1; k < 12; k++) begin
      level_lose = (k == 5);
      level_win  = (k == 6);
      step();
      check($sformatf("freeze_k%0d", k), obs(),
            pk(1, 0, 1, ((k / 4) % 2) == 0, 0, 0, 4'd2));
    end
    level_win  = 1'b0;
    level_lose = 1'b0;
    step();
    check("respawn_entry", obs(), pk(0, 0, 0, 1, 0, 0, 4'd2));
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("respawn_held%0d", k), obs(), pk(0, 0, 0, 1, 0, 0, 4'd2));
    end
    start_button = 1'b1;
    step();
    check("respawn_arm", obs(), pk(0, 0, 0, 1, 0, 0, 4'd2));
    start_button = 1'b0;
    step();
    check("respawn_press", obs(), pk(1, 1, 0, 1, 0, 0, 4'd2));
    start_button = 1'b1;

    lose_cycle(4'd1, 1'b0);
    lose_cycle(4'd0, 1'b1);

    for (int k = 0; k < 3; k++) begin
      start_button = 1'b0;
      level_win    = 1'b1;
      step();
      step();
      start_button = 1'b1;
      level_win    = 1'b0;
      step();
      check($sformatf("over_sticky%0d", k), obs(), pk(0, 0, 0, 1, 0, 1, 4'd0));
    end

    // Asynchronous reset in the middle of FREEZE while mario is blinked off.
    reset = 1'b0;
    step();
    reset = 1'b1;
    start_button = 1'b0;
    step();
    start_button = 1'b1;
    level_lose   = 1'b1;
    step();
    level_lose = 1'b0;
    check("midfreeze_entry", obs(), pk(1, 0, 1, 1, 0, 0, 4'd2));
    repeat (5) step();
    check("midfreeze_blink", obs(), pk(1, 0, 1, 0, 0, 0, 4'd2));
    #2 reset = 1'b0;
    #1;
    check("async_reset", obs(), pk(0, 0, 0, 1, 0, 0, 4'd3));
    step();
    reset = 1'b1;

    // RESPAWN with start released and never pressed again.
    start_button = 1'b0;
    step();
    start_button = 1'b1;
    level_lose   = 1'b1;
    step();
    level_lose = 1'b0;
    repeat (11) step();
    step();
    check("auto_entry", obs(), pk(0, 0, 0, 1, 0, 0, 4'd2));
    repeat (7) step();
    check("auto_wait", obs(), pk(0, 0, 0, 1, 0, 0, 4'd2));
    step();
`ifdef RESPAWN_AUTO_EN
    check("auto_exit", obs(), pk(1, 1, 0, 1, 0, 0, 4'd2));
`else
    check("no_auto_exit", obs(), pk(0, 0, 0, 1, 0, 0, 4'd2));
    repeat (8) step();
    check("no_auto_long", obs(), pk(0, 0, 0, 1, 0, 0, 4'd2));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
